// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Sixteen-entry circular reorder buffer sitting between dispatch and the
//   register file. It allocates one entry per issued instruction, announces
//   the rename to the register file, captures CDB results, answers operand
//   queries by ROB position, and retires the head in program order. A
//   mispredicted branch reaching the head commits normally, then flushes the
//   whole window.
//
// Ports
//   clk, rst, rdy       : clock, synchronous active-high reset, global enable
//   issue_*             : dispatch request (rd, store/branch decode)
//   full, issue_ROB_pos : back-pressure and next allocation position
//   update_*            : rename announcement to the register file
//   cdb_*               : result broadcast (value, mispredict, target PC)
//   qN_ROB_pos/ready/val: combinational operand lookups (N = 1, 2)
//   commit_*            : registered in-order retirement
//   flush, flush_pc     : registered mispredict recovery pulse and target
//
// Configuration
//   ROB_CDB_BYPASS_EN : when defined, operand queries also match the live CDB
//                       (priority over stored state); otherwise queries see
//                       stored state only.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_store,
  input  logic             issue_is_branch,
  output logic             full,
  output logic [ROB_W-1:0] issue_ROB_pos,
  output logic             update_valid,
  output logic [ROB_W-1:0] update_ROB_pos,
  output logic [4:0]       update_rd,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_ROB_pos,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target_pc,
  input  logic [ROB_W-1:0] q1_ROB_pos,
  input  logic [ROB_W-1:0] q2_ROB_pos,
  output logic             q1_ready,
  output logic [31:0]      q1_val,
  output logic             q2_ready,
  output logic [31:0]      q2_val,
  output logic             commit_valid,
  output logic [ROB_W-1:0] commit_ROB_pos,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic             commit_store,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam logic [ROB_W:0]   CountFull = (ROB_W+1)'(ROB_SIZE);
  localparam logic [ROB_W:0]   CountOne  = (ROB_W+1)'(1);
  localparam logic [ROB_W-1:0] PtrOne    = ROB_W'(1);

  // Per-entry control flags
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_is_store;
  logic [ROB_SIZE-1:0] r_is_branch;
  logic [ROB_SIZE-1:0] r_misp;

  // Per-entry data fields (no reset needed: only read behind busy/ready)
  logic [4:0]  r_rd  [ROB_SIZE];
  logic [31:0] r_val [ROB_SIZE];
  logic [31:0] r_tpc [ROB_SIZE];

  logic [ROB_W-1:0] r_head;
  logic [ROB_W-1:0] r_tail;
  logic [ROB_W:0]   r_count;

  logic             r_commit_valid;
  logic [ROB_W-1:0] r_commit_pos;
  logic [4:0]       r_commit_rd;
  logic [31:0]      r_commit_val;
  logic             r_commit_store;
  logic             r_flush;
  logic [31:0]      r_flush_pc;

  logic w_full;
  logic w_issue;
  logic w_cdb_wr;
  logic w_commit;
  logic w_flush_now;

  always_comb begin
    w_full      = (r_count == CountFull);
    // The flush cycle drops both dispatch and CDB: the window was just emptied.
    w_issue     = issue_valid && !w_full && !r_flush;
    w_cdb_wr    = cdb_valid && !r_flush && r_busy[cdb_ROB_pos];
    // Commit decision uses pre-edge state, so a same-cycle CDB to the head
    // only makes it retire on the following edge.
    w_commit    = (r_count != '0) && r_ready[r_head];
    w_flush_now = w_commit && r_is_branch[r_head] && r_misp[r_head];
  end

  assign full           = w_full;
  assign issue_ROB_pos  = r_tail;
  assign update_valid   = w_issue;
  assign update_ROB_pos = r_tail;
  assign update_rd      = issue_rd;

  assign commit_valid   = r_commit_valid;
  assign commit_ROB_pos = r_commit_pos;
  assign commit_rd      = r_commit_rd;
  assign commit_val     = r_commit_val;
  assign commit_store   = r_commit_store;
  assign flush          = r_flush;
  assign flush_pc       = r_flush_pc;

  // Control state, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_is_store     <= '0;
      r_is_branch    <= '0;
      r_misp         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_pos   <= '0;
      r_commit_rd    <= '0;
      r_commit_val   <= '0;
      r_commit_store <= 1'b0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
    end else if (rdy) begin
      r_commit_valid <= w_commit;
      r_commit_store <= w_commit && r_is_store[r_head];
      r_flush        <= w_flush_now;

      if (w_commit) begin
        r_commit_pos <= r_head;
        // Stores never write rd; branches without a link already carry rd=0.
        r_commit_rd  <= r_is_store[r_head] ? 5'd0 : r_rd[r_head];
        r_commit_val <= r_val[r_head];
      end
      if (w_flush_now) begin
        r_flush_pc <= r_tpc[r_head];
      end

      if (w_cdb_wr) begin
        r_ready[cdb_ROB_pos] <= 1'b1;
        r_misp[cdb_ROB_pos]  <= cdb_mispredict;
      end

      // tail is never busy unless full, so issue cannot collide with the CDB
      if (w_issue) begin
        r_busy[r_tail]      <= 1'b1;
        r_ready[r_tail]     <= issue_is_store;
        r_is_store[r_tail]  <= issue_is_store;
        r_is_branch[r_tail] <= issue_is_branch;
        r_misp[r_tail]      <= 1'b0;
      end

      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
      end

      if (w_flush_now) begin
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_commit) r_head <= r_head + PtrOne;
        if (w_issue)  r_tail <= r_tail + PtrOne;
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + CountOne;
          2'b01:   r_count <= r_count - CountOne;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (w_cdb_wr) begin
        r_val[cdb_ROB_pos] <= cdb_val;
        r_tpc[cdb_ROB_pos] <= cdb_target_pc;
      end
      // Clear payload on allocation so a store retires with a defined value.
      if (w_issue) begin
        r_rd[r_tail]  <= issue_rd;
        r_val[r_tail] <= '0;
        r_tpc[r_tail] <= '0;
      end
    end
  end

  // Operand queries
  always_comb begin
    q1_ready = r_ready[q1_ROB_pos];
    q1_val   = r_val[q1_ROB_pos];
    q2_ready = r_ready[q2_ROB_pos];
    q2_val   = r_val[q2_ROB_pos];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_ROB_pos == q1_ROB_pos)) begin
      q1_ready = 1'b1;
      q1_val   = cdb_val;
    end
    if (cdb_valid && (cdb_ROB_pos == q2_ROB_pos)) begin
      q2_ready = 1'b1;
      q2_val   = cdb_val;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_is_store, issue_is_branch;
  logic [4:0]  issue_rd;
  logic        full, update_valid;
  logic [3:0]  issue_ROB_pos, update_ROB_pos;
  logic [4:0]  update_rd;
  logic        cdb_valid, cdb_mispredict;
  logic [3:0]  cdb_ROB_pos;
  logic [31:0] cdb_val, cdb_target_pc;
  logic [3:0]  q1_ROB_pos, q2_ROB_pos;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit_valid, commit_store, flush;
  logic [3:0]  commit_ROB_pos;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, flush_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE(16), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
    .full(full), .issue_ROB_pos(issue_ROB_pos),
    .update_valid(update_valid), .update_ROB_pos(update_ROB_pos), .update_rd(update_rd),
    .cdb_valid(cdb_valid), .cdb_ROB_pos(cdb_ROB_pos), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
    .q1_ROB_pos(q1_ROB_pos), .q2_ROB_pos(q2_ROB_pos),
    .q1_ready(q1_ready), .q1_val(q1_val), .q2_ready(q2_ready), .q2_val(q2_val),
    .commit_valid(commit_valid), .commit_ROB_pos(commit_ROB_pos), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_store(commit_store),
    .flush(flush), .flush_pc(flush_pc)
  );

  // Reference model: the in-flight window as a program-ordered queue.
  typedef struct {
    logic [3:0]  pos;
    logic [4:0]  rd;
    bit          is_store;
    bit          is_branch;
    bit          ready;
    bit          misp;
    logic [31:0] val;
    logic [31:0] tpc;
  } ent_t;

  // Expected retirement, stamped with the edge number it must appear after.
  typedef struct {
    int unsigned at;
    logic [3:0]  pos;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          store;
    bit          flush;
    logic [31:0] fpc;
  } exp_t;

  ent_t        win[$];
  exp_t        sb[$];
  logic [3:0]  m_tail;
  bit          m_flush;
  int unsigned edge_n;
  bit          last_active;
  bit          q1_chk, q2_chk;
  int          n_tests, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [3:0] p);
    foreach (win[i]) if (win[i].pos == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic q_exp(input logic [3:0] p, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (win[i]) if (win[i].pos == p) begin
      r = win[i].ready;
      v = win[i].val;
    end
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && cdb_ROB_pos == p) begin
      r = 1'b1;
      v = cdb_val;
    end
`endif
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_step();
    bit   do_commit, do_issue, fl;
    ent_t h;
    edge_n++;
    fl = 1'b0;
    if (rst) begin
      win.delete();
      m_tail      = '0;
      m_flush     = 1'b0;
      last_active = 1'b1;
    end else if (rdy) begin
      last_active = 1'b1;
      do_commit   = (win.size() > 0) && win[0].ready;
      if (do_commit) h = win[0];
      do_issue    = issue_valid && (win.size() < 16) && !m_flush;
      if (cdb_valid && !m_flush) begin
        foreach (win[i]) if (win[i].pos == cdb_ROB_pos) begin
          win[i].ready = 1'b1;
          win[i].val   = cdb_val;
          win[i].misp  = cdb_mispredict;
          win[i].tpc   = cdb_target_pc;
        end
      end
      if (do_commit) begin
        fl = h.is_branch && h.misp;
        sb.push_back('{at: edge_n, pos: h.pos, rd: (h.is_store ? 5'd0 : h.rd), val: h.val,
                       store: h.is_store, flush: fl, fpc: h.tpc});
        void'(win.pop_front());
      end
      if (fl) begin
        win.delete();
        m_tail = '0;
      end else if (do_issue) begin
        win.push_back('{pos: m_tail, rd: issue_rd, is_store: issue_is_store,
                        is_branch: issue_is_branch, ready: issue_is_store, misp: 1'b0,
                        val: 32'd0, tpc: 32'd0});
        m_tail = m_tail + 4'd1;
      end
      m_flush = fl;
    end else begin
      last_active = 1'b0;
    end
  endtask

  // Called at a negedge with inputs set: check combinational outputs, cross an edge.
  task automatic tick();
    bit          ef, euv, r;
    logic [31:0] v;
    #2;
    ef  = (win.size() == 16);
    euv = issue_valid && !ef && !m_flush;
    chk("full", full, ef);
    chk("issue_ROB_pos", issue_ROB_pos, m_tail);
    chk("update_valid", update_valid, euv);
    chk("update_ROB_pos", update_ROB_pos, m_tail);
    chk("update_rd", update_rd, issue_rd);
    if (q1_chk) begin
      q_exp(q1_ROB_pos, r, v);
      chk("q1_ready", q1_ready, r);
      if (r) chk("q1_val", q1_val, v);
    end
    if (q2_chk) begin
      q_exp(q2_ROB_pos, r, v);
      chk("q2_ready", q2_ready, r);
      if (r) chk("q2_val", q2_val, v);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; rdy = 1;
    issue_valid = 0; issue_rd = '0; issue_is_store = 0; issue_is_branch = 0;
    cdb_valid = 0; cdb_ROB_pos = '0; cdb_val = '0; cdb_mispredict = 0; cdb_target_pc = '0;
    q1_ROB_pos = '0; q2_ROB_pos = '0; q1_chk = 0; q2_chk = 0;
  endtask

  task automatic issue1(input logic [4:0] rd, input bit st, input bit br);
    set_idle();
    issue_valid = 1; issue_rd = rd; issue_is_store = st; issue_is_branch = br;
    tick();
  endtask

  task automatic cdb1(input logic [3:0] p, input logic [31:0] v, input bit mp,
                      input logic [31:0] pc);
    set_idle();
    cdb_valid = 1; cdb_ROB_pos = p; cdb_val = v; cdb_mispredict = mp; cdb_target_pc = pc;
    tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT is due to present a retirement.
  initial begin
    exp_t e;
    logic pv, ps, pf;
    pv = 0; ps = 0; pf = 0;
    forever begin
      @(negedge clk);
      if (edge_n != 0) begin
        if (!last_active) begin
          chk("hold_when_not_rdy", {commit_valid, commit_store, flush}, {pv, ps, pf});
        end else if (sb.size() > 0 && sb[0].at == edge_n) begin
          e = sb.pop_front();
          chk("commit_valid", commit_valid, 1);
          chk("commit_ROB_pos", commit_ROB_pos, e.pos);
          chk("commit_rd", commit_rd, e.rd);
          chk("commit_val", commit_val, e.val);
          chk("commit_store", commit_store, e.store);
          chk("flush", flush, e.flush);
          if (e.flush) chk("flush_pc", flush_pc, e.fpc);
        end else begin
          chk("idle_commit_flush", {commit_valid, commit_store, flush}, 0);
        end
      end
      pv = commit_valid; ps = commit_store; pf = flush;
    end
  end

  initial begin
    logic [3:0] pa, pb;
    int         cand[$];
    int         k;
    n_tests = 0; n_fail = 0; edge_n = 0; last_active = 0;
    m_tail = '0; m_flush = 0;
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("reset_commit_out", {commit_valid, commit_store, flush, commit_ROB_pos, commit_rd}, 0);
    chk("reset_commit_val", commit_val, 0);
    chk("reset_flush_pc", flush_pc, 0);
    chk("reset_full", full, 0);
    chk("reset_issue_pos", issue_ROB_pos, 0);

    // Single issue, query before result, then result and retirement.
    issue1(5'd5, 0, 0);
    set_idle(); q1_ROB_pos = 4'd0; q1_chk = 1; tick();
    cdb1(4'd0, 32'h1234, 0, 0);
    repeat (3) begin set_idle(); tick(); end

    // Fill all 16 entries; tail wraps; full stalls even on the freeing edge.
    for (int i = 0; i < 16; i++) issue1(5'($urandom_range(1, 31)), 0, 0);
    issue1(5'd9, 0, 0);
    set_idle(); issue_valid = 1; issue_rd = 5'd3;
    cdb_valid = 1; cdb_ROB_pos = win[0].pos; cdb_val = 32'hCAFE; tick();
    issue1(5'd4, 0, 0);
    issue1(5'd6, 0, 0);
    while (win.size() > 0) begin
      cdb1(win[win.size()-1].pos, $urandom, 0, 0);
      // Drain from the youngest: entries go ready out of order.
      for (int i = win.size() - 1; i >= 0; i--) if (!win[i].ready) begin
        cdb1(win[i].pos, $urandom, 0, 0);
      end
    end
    repeat (3) begin set_idle(); tick(); end

    // Three entries resolved youngest-first retire on consecutive edges.
    pa = m_tail;
    repeat (3) issue1(5'($urandom_range(1, 31)), 0, 0);
    cdb1(pa + 4'd2, 32'hA2, 0, 0);
    cdb1(pa + 4'd1, 32'hA1, 0, 0);
    cdb1(pa, 32'hA0, 0, 0);
    repeat (4) begin set_idle(); tick(); end

    // Mispredicted JAL with younger work in flight, plus a store.
    pa = m_tail;
    issue1(5'd3, 0, 0);
    pb = m_tail;
    issue1(5'd1, 0, 1);
    issue1(5'd0, 1, 0);
    issue1(5'd7, 0, 0);
    issue1(5'd8, 0, 0);
    cdb1(pb + 4'd2, 32'h22, 0, 0);
    cdb1(pb + 4'd3, 32'h33, 0, 0);
    cdb1(pa, 32'h11, 0, 0);
    cdb1(pb, 32'h44, 1, 32'h100);
    for (int g = 0; g < 8 && !m_flush; g++) begin set_idle(); tick(); end
    // Flush cycle: issue and CDB must both be dropped.
    set_idle(); issue_valid = 1; issue_rd = 5'd7;
    cdb_valid = 1; cdb_ROB_pos = 4'd0; cdb_val = 32'hBAD; tick();
    issue1(5'd9, 0, 0);
    set_idle(); q1_ROB_pos = 4'd0; q1_chk = 1; tick();

    // Same-cycle CDB and query on one entry.
    repeat (3) issue1(5'($urandom_range(1, 31)), 0, 0);
    set_idle(); cdb_valid = 1; cdb_ROB_pos = 4'd3; cdb_val = 32'd7;
    q2_ROB_pos = 4'd3; q2_chk = 1; tick();
    set_idle(); q1_ROB_pos = 4'd3; q1_chk = 1; tick();
    for (int i = 0; i < 3; i++) cdb1(4'(i), 32'(i + 100), 0, 0);
    repeat (4) begin set_idle(); tick(); end

    // Randomized traffic with enable gaps, flushes and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      rdy = ($urandom_range(0, 9) != 0);
      if (c == 1500) rst = 1;
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 31));
      k           = $urandom_range(0, 5);
      issue_is_store  = (k == 0);
      issue_is_branch = (k == 1);
      cand.delete();
      foreach (win[i]) if (!win[i].ready) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = cand[$urandom_range(0, cand.size() - 1)];
        cdb_valid      = 1;
        cdb_ROB_pos    = win[k].pos;
        cdb_val        = $urandom;
        cdb_mispredict = win[k].is_branch ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 15) == 0);
        cdb_target_pc  = $urandom;
      end else if (win.size() < 16 && $urandom_range(0, 3) == 0) begin
        cdb_ROB_pos = 4'($urandom_range(0, 15));
        if (!in_win(cdb_ROB_pos)) begin
          cdb_valid = 1;
          cdb_val   = $urandom;
        end
      end
      if (win.size() > 0) begin
        q1_ROB_pos = win[$urandom_range(0, win.size() - 1)].pos; q1_chk = 1;
        q2_ROB_pos = cdb_valid ? cdb_ROB_pos : win[0].pos;
        q2_chk     = in_win(q2_ROB_pos);
      end
      tick();
    end

    // Drain whatever is still in flight.
    for (int g = 0; g < 300 && win.size() > 0; g++) begin
      set_idle();
      foreach (win[i]) if (!win[i].ready && !cdb_valid) begin
        cdb_valid = 1; cdb_ROB_pos = win[i].pos; cdb_val = $urandom;
      end
      tick();
    end
    repeat (4) begin set_idle(); tick(); end
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Sixteen-entry circular reorder buffer for the out-of-order RISC-V core. It sits between dispatch and the register file:
- Allocates an entry per issued instruction and announces the rename (`update_*`) to the register file.
- Captures results broadcast on the CDB.
- Answers operand queries by ROB position.
- Retires the head in program order through the `commit_*` port, or flushes the whole window on a mispredicted branch.

## Interface
Parameters:
- `ROB_SIZE`, 16: entry count; must equal 2^`ROB_W`.
- `ROB_W`, 4: ROB position width; matches the register file's 4-bit reorder tag.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state and registered outputs hold.
- `issue_valid` in 1: dispatch presents an instruction this cycle.
- `issue_rd` in 5: destination register; 0 means no register write.
- `issue_is_store` in 1: entry is a store (no `rd` write; signals LSB at commit).
- `issue_is_branch` in 1: entry is a branch or jump (resolved via CDB).
- `full` out 1: no free entry; dispatch must not issue.
- `issue_ROB_pos` out 4: current tail index, i.e. the position the next issued entry receives.
- `update_valid` out 1: `issue_valid && !full && !flush`.
- `update_ROB_pos` out 4: equals the tail.
- `update_rd` out 5: equals `issue_rd`.
- `cdb_valid` in 1: result broadcast this cycle.
- `cdb_ROB_pos` in 4: producing entry.
- `cdb_val` in 32: result value.
- `cdb_mispredict` in 1: branch resolved against its prediction.
- `cdb_target_pc` in 32: correct PC for a mispredicted branch.
- `q1_ROB_pos`, `q2_ROB_pos` in 4: operand tags taken from `reg1/2_reorder_ROB_pos`.
- `q1_ready`, `q2_ready` out 1: the queried entry has its value.
- `q1_val`, `q2_val` out 32: value of the queried entry.
- `commit_valid` out 1: registered; one retirement this cycle.
- `commit_ROB_pos` out 4: registered; position of the retiring entry.
- `commit_rd` out 5: registered; destination of the retiring entry.
- `commit_val` out 32: registered; value of the retiring entry.
- `commit_store` out 1: registered; the retiring entry is a store, so the LSB may perform it.
- `flush` out 1: registered; mispredict recovery pulse.
- `flush_pc` out 32: registered; fetch redirect target.

## Operation
- Entry fields: `busy`, `ready`, `rd[4:0]`, `val[31:0]`, `is_store`, `is_branch`, `mispredict`, `target_pc[31:0]`.
- Pointers: `head`, `tail` (4-bit, wrap modulo 16) and `count` (5-bit, 0..16).
- `full` = (`count` == 16); combinational from registered `count`.

Issue (`update_valid`):
- Entry[tail] gets `busy`=1, `ready`=0, plus the decoded fields.
- `tail`+1.
- Stores set `ready`=1 at issue.

Writeback:
- Applies when `cdb_valid` and entry[`cdb_ROB_pos`].`busy` are both set.
- Sets `ready`=1, `val`, `mispredict`, `target_pc`.
- CDB targeting a non-busy entry is ignored.

Commit:
- Occurs when `count`>0 and entry[head].`ready`.
- Registers `commit_*` from entry[head], clears `busy`, `head`+1.
- `commit_rd` is forced to 0 for stores and for branches without `rd`.

Mispredict commit:
- Applies when the head is a branch with `mispredict`=1.
- The commit happens normally (a JAL/JALR link value is written).
- Also sets `flush`=1 and `flush_pc`=`target_pc`.
- In the same edge, all `busy` bits clear and `head`=`tail`=`count`=0.

Other rules:
- During the cycle `flush`=1, issue is suppressed (`update_valid`=0) and CDB input is ignored.
- `count` update per edge: +1 on issue, −1 on commit; both at once leaves it unchanged; a flush edge sets it to 0.
- Queries: `qN_ready` = entry[`qN_ROB_pos`].`ready`; `qN_val` = entry.`val`. Combinational.

## Timing
- Reset: `head`=`tail`=`count`=0, all `busy`/`ready`=0, all registered outputs 0, `full`=0.
- Issue→entry visible: 1 cycle.
- CDB→ready visible to queries: 1 cycle, or 0 with the configuration macro defined.
- Head ready→`commit_valid`: 1 cycle.
- Maximum throughput: 1 commit per cycle.
- `commit_valid`, `commit_store` and `flush` are single-cycle pulses unless `rdy` is low, in which case they hold.
- At `count`=16 with a commit in the same cycle, issue still stalls (`full` is from the registered count); the freed slot is usable the next cycle.
- Issuing into `tail`==15 wraps `tail` to 0.
- A CDB write and a commit on the same entry in one cycle: the commit uses the old state (not ready), so it commits next cycle.
- `rst` mid-operation overrides everything: the state above is restored on the next edge, and a pending commit is dropped.

## Configuration
- `ROB_CDB_BYPASS_EN` defined: `qN_ready`/`qN_val` also match the live CDB (`cdb_valid && cdb_ROB_pos==qN_ROB_pos` → ready=1, value=`cdb_val`), with priority over stored state.
- Undefined: queries reflect stored state only, adding one cycle of operand latency.

## Test plan
- Reset, then issue `rd`=5 → `update_valid`=1, `update_ROB_pos`=0. Next cycle: `q1_ROB_pos`=0 gives `q1_ready`=0.
- CDB pos 0, val 0x1234 → two cycles later `commit_valid`=1, `commit_rd`=5, `commit_val`=0x1234, `commit_ROB_pos`=0.
- Issue 16 entries without CDB → `full`=1 and `issue_ROB_pos` wraps to 0. Then CDB to pos 0 → one commit, and `full` drops the following cycle.
- Out-of-order CDB (pos 2, then 1, then 0) → commits appear in order 0, 1, 2 on consecutive cycles.
- Branch at pos 1 resolved with `cdb_mispredict`=1, `target_pc`=0x100, and entries 2–4 in flight → `flush`=1, `flush_pc`=0x100; next cycle `count`=0 and `issue_ROB_pos`=0.
- With `ROB_CDB_BYPASS_EN`: CDB pos 3, val 7, with `q2_ROB_pos`=3 in the same cycle → `q2_ready`=1, `q2_val`=7. Without the macro → `q2_ready`=0 that cycle.
